card_hand_dp: RTL and testbench
===============================

Name: card_hand_dp

Overview:
- Parametrised datapath for the Big-2 card engine.
- Holds every player's hand, each player's remaining-card count, and the current top card with its owner.
- Executes one command at a time from the game controller: load, compare, play, search, clear top.
- Adds an N-player search for the *smallest* beating card and winner detection.

Parameters:
- NUM_PLAYERS, 2, number of hands (2..8)
- HAND_SIZE, 4, card slots per hand (2..16)
- CARD_W, 6, card code width; code 0 means empty slot; a larger code beats a smaller one
- Derived localparams: PID_W = max(1, clog2(NUM_PLAYERS)); SLOT_W = max(1, clog2(HAND_SIZE)); CNT_W = clog2(HAND_SIZE+1)

Ports:
- clka  in  1  clock; all state updates on the rising edge
- RESTART  in  1  asynchronous active-high reset
- cmd_valid  in  1  command strobe; accepted when cmd_valid && cmd_ready
- cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 COMPARE, 3 SEARCH, 4 PLAY, 5 CLEAR_TOP, 6 PASS
- cmd_player  in  PID_W  target player
- cmd_slot  in  SLOT_W  target slot, 0-based
- load_cards  in  NUM_PLAYERS*HAND_SIZE*CARD_W  initial hands; player p slot s at bits [(p*HAND_SIZE+s)*CARD_W +: CARD_W]
- cmd_ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- is_larger  out  1  result of the last COMPARE or PLAY
- found  out  1  SEARCH found a beating card
- found_slot  out  SLOT_W  slot of that card
- top_card  out  CARD_W  current top card (0 = none)
- top_owner  out  PID_W  player who laid top_card
- hand_cards  out  same as load_cards  live hands
- hand_count  out  NUM_PLAYERS*CNT_W  remaining nonzero cards per player
- winner_valid  out  1  a player has emptied their hand
- winner_id  out  PID_W  that player

Behaviour:
- Reset (asynchronous, any state, including mid-SEARCH): every output and register is 0; state returns to IDLE. The state is IDLE, so cmd_ready is 1 during reset.
- FSM states: IDLE, SCAN, FIN.
  - IDLE + accepted command: single-cycle ops go to FIN; SEARCH goes to SCAN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Latency: single-cycle ops have done 1 cycle after accept; SEARCH has done HAND_SIZE+1 cycles after accept.
- LOAD: hands ← load_cards; each count ← number of nonzero slots; top_card, top_owner, winner_valid, winner_id, is_larger, found cleared. LOAD is legal after a win.
- COMPARE: is_larger ← (card≠0 && card>top_card). No other state changes.
- PLAY:
  - If card≠0 && card>top_card: top_card ← card; top_owner ← player; slot ← 0; count −1; is_larger ← 1.
  - Otherwise: is_larger ← 0 and nothing else changes.
  - If the count reaches 0: winner_valid ← 1 and winner_id ← player, in the same cycle.
- SEARCH:
  - Scans slots 0..HAND_SIZE−1, one per cycle, tracking the minimum card that is >top_card.
  - Ties resolve to the lowest slot.
  - found/found_slot are updated at FIN; if nothing beats the top, found=0 and found_slot=0.
  - Hands are not modified.
- CLEAR_TOP: top_card ← 0; top_owner ← 0.
- NOP, op 7, or cmd_player ≥ NUM_PLAYERS: done pulse, no state change.
- While winner_valid=1: every op except LOAD is a no-op that still pulses done.
- cmd_valid while cmd_ready=0 is ignored; the held command is not queued.
- Count never underflows: PLAY on an empty slot is rejected by the card≠0 test.

Optional Feature:
- Macro: CARD_DP_PASS_TRACK_EN.
- Defined:
  - An internal pass counter (width PID_W+1) increments on PASS and clears on any successful PLAY, CLEAR_TOP, or LOAD.
  - When it reaches NUM_PLAYERS−1, top_card/top_owner clear automatically in the same FIN cycle and the counter resets.
  - This is the Big-2 "round won" rule.
- Not defined: PASS behaves as NOP; no counter exists.

Decomposition:
- Package card_dp_pkg: opcode constants, state encoding, EMPTY_CARD=0, and width helper functions.
- One sub-module, card_min_above: a combinational step taking (card, top, best_valid, best_card, best_slot, slot) and returning the updated best. It is instantiated once and used per SCAN cycle.

Test Plan:
- Reset during SCAN (HAND_SIZE=4, cycle 2) → all outputs 0, cmd_ready=1 next cycle, no done pulse.
- LOAD P0={0x05,0x12,0x00,0x20}, P1={0x07,0x03,0x30,0x11} → counts 3 and 4; top=0; done 1 cycle after accept.
- top=0x06, SEARCH P1 → found=1, found_slot=0 (0x07, the minimum above 0x06, not 0x30); done at accept+5.
- PLAY P0 slot1 with top=0x06 → top=0x12, owner=0, P0 slot1=0, count 3→2, is_larger=1.
- PLAY P0 slot1 again → is_larger=0, no change; P0 with count=1 plays its last card → winner_valid=1, winner_id=0; subsequent PLAY ignored; LOAD clears the win.
- With CARD_DP_PASS_TRACK_EN, NUM_PLAYERS=3, top=0x20: two PASS commands → top=0 after the second; a PLAY between the passes resets the counter, so top is retained.

Source files
------------

// File: rtl/card_dp_pkg.sv
// Shared opcodes, FSM states and width helpers for the Big-2 hand datapath.
package card_dp_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_LOAD      = 3'd1,
    OP_COMPARE   = 3'd2,
    OP_SEARCH    = 3'd3,
    OP_PLAY      = 3'd4,
    OP_CLEAR_TOP = 3'd5,
    OP_PASS      = 3'd6,
    OP_RSVD      = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int unsigned EMPTY_CARD = 0;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/card_hand_dp_min_above.sv
// One SCAN step: folds a single slot into the running "smallest card above top".
module card_min_above
  import card_dp_pkg::*;
#(
  parameter int unsigned CARD_W = 6,
  parameter int unsigned SLOT_W = 2
) (
  input  logic [CARD_W-1:0] card,
  input  logic [CARD_W-1:0] top,
  input  logic              best_valid,
  input  logic [CARD_W-1:0] best_card,
  input  logic [SLOT_W-1:0] best_slot,
  input  logic [SLOT_W-1:0] slot,
  output logic              next_valid,
  output logic [CARD_W-1:0] next_card,
  output logic [SLOT_W-1:0] next_slot
);

  logic beats;
  logic take;

  // Strict less-than keeps the earlier (lower) slot on ties, as slots scan upward.
  always_comb begin
    beats      = (card != CARD_W'(EMPTY_CARD)) && (card > top);
    take       = beats && (!best_valid || (card < best_card));
    next_valid = best_valid || beats;
    next_card  = take ? card : best_card;
    next_slot  = take ? slot : best_slot;
  end

endmodule

// File: rtl/card_hand_dp.sv
// Big-2 hand datapath: hands, counts, top card, smallest-beater search, winner.
// Optional CARD_DP_PASS_TRACK_EN: consecutive PASS counting clears the top card.
module card_hand_dp
  import card_dp_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS = 2,
  parameter  int unsigned HAND_SIZE   = 4,
  parameter  int unsigned CARD_W      = 6,
  localparam int unsigned PID_W       = idx_width(NUM_PLAYERS),
  localparam int unsigned SLOT_W      = idx_width(HAND_SIZE),
  localparam int unsigned CNT_W       = count_width(HAND_SIZE),
  localparam int unsigned HAND_W      = NUM_PLAYERS * HAND_SIZE * CARD_W
) (
  input  logic                         clka,
  input  logic                         RESTART,
  input  logic                         cmd_valid,
  input  logic [2:0]                   cmd_op,
  input  logic [PID_W-1:0]             cmd_player,
  input  logic [SLOT_W-1:0]            cmd_slot,
  input  logic [HAND_W-1:0]            load_cards,
  output logic                         cmd_ready,
  output logic                         done,
  output logic                         is_larger,
  output logic                         found,
  output logic [SLOT_W-1:0]            found_slot,
  output logic [CARD_W-1:0]            top_card,
  output logic [PID_W-1:0]             top_owner,
  output logic [HAND_W-1:0]            hand_cards,
  output logic [NUM_PLAYERS*CNT_W-1:0] hand_count,
  output logic                         winner_valid,
  output logic [PID_W-1:0]             winner_id
);

  state_e state_q, state_d;
  op_e    op;

  logic [CARD_W-1:0] hand_q   [NUM_PLAYERS][HAND_SIZE];
  logic [CNT_W-1:0]  count_q  [NUM_PLAYERS];
  logic [CNT_W-1:0]  load_cnt [NUM_PLAYERS];

  logic [PID_W-1:0]  scan_player;
  logic [SLOT_W-1:0] scan_idx;
  logic              best_valid;
  logic [CARD_W-1:0] best_card;
  logic [SLOT_W-1:0] best_slot;
  logic [CARD_W-1:0] scan_card;
  logic              step_valid;
  logic [CARD_W-1:0] step_card;
  logic [SLOT_W-1:0] step_slot;
  logic              scan_last;

  logic              accept;
  logic              player_ok;
  logic              slot_ok;
  logic              act;
  logic [CARD_W-1:0] sel_card;
  logic [CNT_W-1:0]  sel_count;
  logic              beats;

`ifdef CARD_DP_PASS_TRACK_EN
  localparam int unsigned PCNT_W = PID_W + 1;
  logic [PCNT_W-1:0] pass_cnt;
`endif

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign accept    = cmd_valid && cmd_ready;
  assign player_ok = {1'b0, cmd_player} < (PID_W + 1)'(NUM_PLAYERS);
  assign slot_ok   = {1'b0, cmd_slot} < (SLOT_W + 1)'(HAND_SIZE);
  // Once someone has won, only LOAD may touch state.
  assign act       = player_ok && (!winner_valid || (op == OP_LOAD));
  assign scan_last = (scan_idx == SLOT_W'(HAND_SIZE - 1));

  always_comb begin
    sel_card  = '0;
    sel_count = '0;
    if (player_ok) begin
      sel_count = count_q[cmd_player];
      if (slot_ok) sel_card = hand_q[cmd_player][cmd_slot];
    end
    beats = (sel_card != CARD_W'(EMPTY_CARD)) && (sel_card > top_card);
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      load_cnt[p] = '0;
      for (int unsigned s = 0; s < HAND_SIZE; s++) begin
        if (load_cards[(p*HAND_SIZE+s)*CARD_W +: CARD_W] != CARD_W'(EMPTY_CARD))
          load_cnt[p] = load_cnt[p] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hand_cards = '0;
    hand_count = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      hand_count[p*CNT_W +: CNT_W] = count_q[p];
      for (int unsigned s = 0; s < HAND_SIZE; s++)
        hand_cards[(p*HAND_SIZE+s)*CARD_W +: CARD_W] = hand_q[p][s];
    end
  end

  assign scan_card = hand_q[scan_player][scan_idx];

  card_min_above #(
    .CARD_W (CARD_W),
    .SLOT_W (SLOT_W)
  ) u_min_above (
    .card       (scan_card),
    .top        (top_card),
    .best_valid (best_valid),
    .best_card  (best_card),
    .best_slot  (best_slot),
    .slot       (scan_idx),
    .next_valid (step_valid),
    .next_card  (step_card),
    .next_slot  (step_slot)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept)
          state_d = (act && (op == OP_SEARCH)) ? ST_SCAN : ST_FIN;
      end
      ST_SCAN: if (scan_last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge RESTART) begin
    if (RESTART) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clka or posedge RESTART) begin
    if (RESTART) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        count_q[p] <= '0;
        for (int unsigned s = 0; s < HAND_SIZE; s++) hand_q[p][s] <= '0;
      end
      top_card     <= '0;
      top_owner    <= '0;
      is_larger    <= 1'b0;
      found        <= 1'b0;
      found_slot   <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      scan_player  <= '0;
      scan_idx     <= '0;
      best_valid   <= 1'b0;
      best_card    <= '0;
      best_slot    <= '0;
`ifdef CARD_DP_PASS_TRACK_EN
      pass_cnt     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && act) begin
            case (op)
              OP_LOAD: begin
                for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                  count_q[p] <= load_cnt[p];
                  for (int unsigned s = 0; s < HAND_SIZE; s++)
                    hand_q[p][s] <= load_cards[(p*HAND_SIZE+s)*CARD_W +: CARD_W];
                end
                top_card     <= '0;
                top_owner    <= '0;
                winner_valid <= 1'b0;
                winner_id    <= '0;
                is_larger    <= 1'b0;
                found        <= 1'b0;
                found_slot   <= '0;
`ifdef CARD_DP_PASS_TRACK_EN
                pass_cnt     <= '0;
`endif
              end
              OP_COMPARE: is_larger <= beats;
              OP_SEARCH: begin
                scan_player <= cmd_player;
                scan_idx    <= '0;
                best_valid  <= 1'b0;
                best_card   <= '0;
                best_slot   <= '0;
              end
              OP_PLAY: begin
                is_larger <= beats;
                if (beats) begin
                  top_card                   <= sel_card;
                  top_owner                  <= cmd_player;
                  hand_q[cmd_player][cmd_slot] <= '0;
                  count_q[cmd_player]        <= sel_count - CNT_W'(1);
                  if (sel_count == CNT_W'(1)) begin
                    winner_valid <= 1'b1;
                    winner_id    <= cmd_player;
                  end
`ifdef CARD_DP_PASS_TRACK_EN
                  pass_cnt <= '0;
`endif
                end
              end
              OP_CLEAR_TOP: begin
                top_card  <= '0;
                top_owner <= '0;
`ifdef CARD_DP_PASS_TRACK_EN
                pass_cnt  <= '0;
`endif
              end
`ifdef CARD_DP_PASS_TRACK_EN
              // Everyone else passed: the round is won and the table is cleared.
              OP_PASS: begin
                if (pass_cnt + PCNT_W'(1) == PCNT_W'(NUM_PLAYERS - 1)) begin
                  top_card  <= '0;
                  top_owner <= '0;
                  pass_cnt  <= '0;
                end else begin
                  pass_cnt <= pass_cnt + PCNT_W'(1);
                end
              end
`endif
              default: ;
            endcase
          end
        end
        ST_SCAN: begin
          best_valid <= step_valid;
          best_card  <= step_card;
          best_slot  <= step_slot;
          scan_idx   <= scan_idx + SLOT_W'(1);
          if (scan_last) begin
            found      <= step_valid;
            found_slot <= step_valid ? step_slot : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_hand_dp.sv
// Scoreboard bench for card_hand_dp: directed commands push hand-computed results; a monitor checks them on done.
module tb_card_hand_dp;

  localparam int NP = 2;
  localparam int HS = 4;
  localparam int CW = 6;

  localparam int NOP = 0, LOAD = 1, CMP = 2, SRCH = 3, PLAY = 4, CLRT = 5, PASS = 6;

  logic          clka = 1'b0;
  logic          RESTART;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [0:0]    cmd_player;
  logic [1:0]    cmd_slot;
  logic [47:0]   load_cards;
  logic          cmd_ready;
  logic          done;
  logic          is_larger;
  logic          found;
  logic [1:0]    found_slot;
  logic [5:0]    top_card;
  logic [0:0]    top_owner;
  logic [47:0]   hand_cards;
  logic [5:0]    hand_count;
  logic          winner_valid;
  logic [0:0]    winner_id;

  card_hand_dp #(
    .NUM_PLAYERS (NP),
    .HAND_SIZE   (HS),
    .CARD_W      (CW)
  ) dut (
    .clka         (clka),
    .RESTART      (RESTART),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_player   (cmd_player),
    .cmd_slot     (cmd_slot),
    .load_cards   (load_cards),
    .cmd_ready    (cmd_ready),
    .done         (done),
    .is_larger    (is_larger),
    .found        (found),
    .found_slot   (found_slot),
    .top_card     (top_card),
    .top_owner    (top_owner),
    .hand_cards   (hand_cards),
    .hand_count   (hand_count),
    .winner_valid (winner_valid),
    .winner_id    (winner_id)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc = cyc + 1;

  typedef struct {
    int          step;
    int          lat;
    int          acc;
    logic        il;
    logic        fnd;
    logic [1:0]  fslot;
    logic [5:0]  top;
    logic        owner;
    logic [5:0]  cnt;
    logic        wv;
    logic        wid;
    logic [47:0] hands;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  // Hand-maintained expectation of the DUT's architectural state.
  logic [5:0] m_hand [NP][HS];
  logic [2:0] m_cnt  [NP];
  logic [5:0] m_top;
  logic       m_owner, m_il, m_found, m_wv, m_wid;
  logic [1:0] m_fslot;

  task automatic chk(input string nm, input int st, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL step%0d %s: got 'h%0h required 'h%0h", st, nm, got, req);
    end
  endtask

  function automatic logic [47:0] pack_model();
    logic [47:0] v;
    v = '0;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < HS; s++) v[(p*HS+s)*CW +: CW] = m_hand[p][s];
    return v;
  endfunction

  task automatic model_zero();
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = '0;
      for (int s = 0; s < HS; s++) m_hand[p][s] = '0;
    end
    m_top = '0; m_owner = 0; m_il = 0; m_found = 0; m_fslot = '0; m_wv = 0; m_wid = 0;
  endtask

  task automatic set_load(input logic [5:0] a0, a1, a2, a3, b0, b1, b2, b3);
    load_cards = {b3, b2, b1, b0, a3, a2, a1, a0};
    m_hand[0][0] = a0; m_hand[0][1] = a1; m_hand[0][2] = a2; m_hand[0][3] = a3;
    m_hand[1][0] = b0; m_hand[1][1] = b1; m_hand[1][2] = b2; m_hand[1][3] = b3;
  endtask

  task automatic issue_poke(input int op, input int pl, input int sl, input int lat,
                            input int poke_at, input int poke_op);
    exp_t e;
    int   t;
    @(negedge clka);
    step++;
    e.step = step; e.lat = lat; e.acc = cyc;
    e.il = m_il; e.fnd = m_found; e.fslot = m_fslot; e.top = m_top; e.owner = m_owner;
    e.cnt = {m_cnt[1], m_cnt[0]}; e.wv = m_wv; e.wid = m_wid; e.hands = pack_model();
    sb.push_back(e);
    cmd_valid  = 1'b1;
    cmd_op     = 3'(op);
    cmd_player = 1'(pl);
    cmd_slot   = 2'(sl);
    @(negedge clka);
    cmd_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      if (t == poke_at) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'(poke_op);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clka);
      t++;
    end
    cmd_valid = 1'b0;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL step%0d done_timeout: got no done in 40 cycles, required done", step);
      sb.delete();
    end
  endtask

  task automatic issue(input int op, input int pl, input int sl, input int lat);
    issue_poke(op, pl, sl, lat, -1, 0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_cmd_ready"}, step, cmd_ready, 1);
    chk({tag, "_done"}, step, done, 0);
    chk({tag, "_top"}, step, {top_owner, top_card}, 0);
    chk({tag, "_hands"}, step, hand_cards, 0);
    chk({tag, "_counts"}, step, hand_count, 0);
    chk({tag, "_flags"}, step, {winner_valid, winner_id, is_larger, found, found_slot}, 0);
  endtask

  always @(negedge clka) begin
    if (!RESTART && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done at cycle %0d: got done=1 required 0", cyc);
      end else begin
        cur = sb.pop_front();
        chk("latency", cur.step, cyc - cur.acc, cur.lat);
        chk("cmd_ready", cur.step, cmd_ready, 0);
        chk("top_card", cur.step, top_card, cur.top);
        chk("top_owner", cur.step, top_owner, cur.owner);
        chk("is_larger", cur.step, is_larger, cur.il);
        chk("found", cur.step, found, cur.fnd);
        chk("found_slot", cur.step, found_slot, cur.fslot);
        chk("hand_count", cur.step, hand_count, cur.cnt);
        chk("winner", cur.step, {winner_valid, winner_id}, {cur.wv, cur.wid});
        chk("hand_cards", cur.step, hand_cards, cur.hands);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESTART = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_player = '0; cmd_slot = '0; load_cards = '0;
    model_zero();
    repeat (2) @(negedge clka);
    check_idle_zero("reset");
    RESTART = 1'b0;

    // Initial deal: counts skip empty slot.
    set_load(6'h05, 6'h12, 6'h00, 6'h20, 6'h07, 6'h03, 6'h30, 6'h11);
    m_cnt[0] = 3; m_cnt[1] = 4;
    issue(LOAD, 0, 0, 1);
    m_il = 1; issue(CMP, 1, 1, 1);          // 03 > empty table
    m_il = 0; issue(CMP, 0, 2, 1);          // empty slot never beats
    m_found = 1; m_fslot = 1; issue(SRCH, 1, 0, HS + 1);

    set_load(6'h05, 6'h12, 6'h06, 6'h20, 6'h07, 6'h03, 6'h30, 6'h11);
    m_cnt[0] = 4; m_cnt[1] = 4; m_found = 0; m_fslot = 0;
    issue(LOAD, 0, 0, 1);
    m_top = 6'h06; m_owner = 0; m_hand[0][2] = 0; m_cnt[0] = 3; m_il = 1;
    issue(PLAY, 0, 2, 1);
    m_found = 1; m_fslot = 0; issue(SRCH, 1, 0, HS + 1);   // 07, not 30 or 11
    m_top = 6'h12; m_hand[0][1] = 0; m_cnt[0] = 2; m_il = 1;
    issue(PLAY, 0, 1, 1);
    m_il = 0; issue(PLAY, 0, 1, 1);         // slot now empty
    m_il = 0; issue(PLAY, 1, 1, 1);         // 03 below 12
    m_found = 1; m_fslot = 3; issue(SRCH, 0, 0, HS + 1);
    m_top = 6'h30; m_owner = 1; m_hand[1][2] = 0; m_cnt[1] = 3; m_il = 1;
    issue(PLAY, 1, 2, 1);
    m_found = 0; m_fslot = 0; issue(SRCH, 0, 0, HS + 1);   // nothing above 30

`ifdef CARD_DP_PASS_TRACK_EN
    m_top = 0; m_owner = 0;
`endif
    issue(PASS, 0, 0, 1);
    m_top = 0; m_owner = 0; issue(CLRT, 0, 0, 1);
    m_top = 6'h20; m_owner = 0; m_hand[0][3] = 0; m_cnt[0] = 1; m_il = 1;
    issue(PLAY, 0, 3, 1);
    m_top = 0; m_owner = 0; issue(CLRT, 1, 0, 1);
    m_top = 6'h05; m_hand[0][0] = 0; m_cnt[0] = 0; m_il = 1; m_wv = 1; m_wid = 0;
    issue(PLAY, 0, 0, 1);                   // last card wins
    issue(PLAY, 1, 0, 1);                   // ignored after win
    issue(CMP, 1, 1, 1);                    // would clear is_larger if not ignored
    issue(SRCH, 1, 0, 1);                   // no scan after win
    issue(NOP, 0, 0, 1);
    issue(7, 1, 3, 1);

    set_load(6'h05, 6'h12, 6'h00, 6'h20, 6'h07, 6'h03, 6'h30, 6'h11);
    m_cnt[0] = 3; m_cnt[1] = 4; m_top = 0; m_owner = 0; m_il = 0; m_found = 0; m_fslot = 0;
    m_wv = 0; m_wid = 0;
    issue(LOAD, 1, 0, 1);
    m_top = 6'h07; m_owner = 1; m_hand[1][0] = 0; m_cnt[1] = 3; m_il = 1;
    issue(PLAY, 1, 0, 1);
    m_found = 1; m_fslot = 1;
    issue_poke(SRCH, 0, 0, HS + 1, 1, CLRT);  // CLEAR_TOP while busy must be dropped

    set_load(6'h09, 6'h08, 6'h08, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04);
    m_cnt[0] = 4; m_cnt[1] = 4; m_top = 0; m_owner = 0; m_il = 0; m_found = 0; m_fslot = 0;
    issue(LOAD, 0, 0, 1);
    m_top = 6'h04; m_owner = 1; m_hand[1][3] = 0; m_cnt[1] = 3; m_il = 1;
    issue(PLAY, 1, 3, 1);
    m_found = 1; m_fslot = 1; issue(SRCH, 0, 0, HS + 1);   // tie on 08 -> lower slot

    // Reset in the middle of a SEARCH scan.
    @(negedge clka);
    step++;
    cmd_valid = 1'b1; cmd_op = 3'(SRCH); cmd_player = 1'(1); cmd_slot = '0;
    @(negedge clka);
    cmd_valid = 1'b0;
    @(negedge clka);
    RESTART = 1'b1;
    #1;
    model_zero();
    check_idle_zero("async_reset");
    @(negedge clka);
    check_idle_zero("reset_held");
    RESTART = 1'b0;
    @(negedge clka);
    chk("post_reset_ready", step, cmd_ready, 1);
    repeat (6) @(negedge clka);

    set_load(6'h05, 6'h12, 6'h00, 6'h20, 6'h07, 6'h03, 6'h30, 6'h11);
    m_cnt[0] = 3; m_cnt[1] = 4;
    issue(LOAD, 0, 0, 1);
    repeat (3) @(negedge clka);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
